// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core.
// Handles CSR read/modify/write, trap/mret state, 64-bit counters and irq pending.
module csr_file #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter logic [XLEN-1:0] HART_ID      = '0,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csr_en,
  input  logic [1:0]      i_csr_op,
  input  logic [11:0]     i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_no_write,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_illegal,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic [XLEN-1:0] i_trap_val,
  input  logic            i_mret,
  input  logic            i_instret,
  input  logic            i_irq_ext,
  input  logic            i_irq_timer,
  input  logic            i_irq_sw,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc,
  output logic            o_irq_pending
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(32'h0000_0888);
  localparam logic [XLEN-1:0] MISA_VAL = XLEN'(32'h4000_0100);

  logic              st_mie;
  logic              st_mpie;
  logic [XLEN-1:0]   mie_q;
  logic [XLEN-1:0]   mtvec_q;
  logic [XLEN-1:0]   mscratch_q;
  logic [XLEN-1:0]   mepc_q;
  logic [XLEN-1:0]   mcause_q;
  logic [XLEN-1:0]   mtval_q;
  logic [2*XLEN-1:0] mcycle_q;
  logic [2*XLEN-1:0] minstret_q;

  logic [XLEN-1:0] mstatus_v;
  logic [XLEN-1:0] mip_v;
  logic [XLEN-1:0] wval;
  logic            mapped;
  logic            ro;
  logic            wr;

  always_comb begin
    mstatus_v = '0;
    mstatus_v[12:11] = 2'b11;
    mstatus_v[7] = st_mpie;
    mstatus_v[3] = st_mie;
    mip_v = '0;
    mip_v[11] = i_irq_ext;
    mip_v[7] = i_irq_timer;
    mip_v[3] = i_irq_sw;
  end

  always_comb begin
    o_rdata = '0;
    mapped = 1'b1;
    ro = (i_addr[11:10] == 2'b11);
    case (i_addr)
      A_MSTATUS:  o_rdata = mstatus_v;
      A_MISA: begin
        o_rdata = MISA_VAL;
        ro = 1'b1;
      end
      A_MIE:      o_rdata = mie_q;
      A_MTVEC:    o_rdata = mtvec_q;
      A_MSCRATCH: o_rdata = mscratch_q;
      A_MEPC:     o_rdata = mepc_q;
      A_MCAUSE:   o_rdata = mcause_q;
      A_MTVAL:    o_rdata = mtval_q;
      A_MIP: begin
        o_rdata = mip_v;
        ro = 1'b1;
      end
      A_MCYCLE: begin
        if (HAS_COUNTERS) o_rdata = mcycle_q[XLEN-1:0];
        else mapped = 1'b0;
      end
      A_MINSTRET: begin
        if (HAS_COUNTERS) o_rdata = minstret_q[XLEN-1:0];
        else mapped = 1'b0;
      end
      A_MCYCLEH: begin
        if (HAS_COUNTERS) o_rdata = mcycle_q[2*XLEN-1:XLEN];
        else mapped = 1'b0;
      end
      A_MINSTRETH: begin
        if (HAS_COUNTERS) o_rdata = minstret_q[2*XLEN-1:XLEN];
        else mapped = 1'b0;
      end
      A_MHARTID:  o_rdata = HART_ID;
      default:    mapped = 1'b0;
    endcase
  end

  assign o_illegal = i_csr_en &
    (!mapped | (ro & (i_csr_op != 2'b00) & !i_no_write));

  // trap and mret own the edge; a concurrent CSR write is dropped
  assign wr = i_csr_en & (i_csr_op != 2'b00) & !i_no_write &
    !o_illegal & !i_trap & !i_mret;

  always_comb begin
    unique case (i_csr_op)
      OP_RW:   wval = i_wdata;
      OP_RS:   wval = o_rdata | i_wdata;
      OP_RC:   wval = o_rdata & ~i_wdata;
      default: wval = o_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET & ~XLEN'(3);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (i_trap) begin
      mepc_q   <= i_trap_pc & ~XLEN'(3);
      mcause_q <= i_trap_cause;
      mtval_q  <= i_trap_val;
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
    end else if (i_mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr) begin
      case (i_addr)
        A_MSTATUS: begin
          st_mie  <= wval[3];
          st_mpie <= wval[7];
        end
        A_MIE:      mie_q <= wval & MIE_MASK;
        A_MTVEC:    mtvec_q <= wval & ~XLEN'(3);
        A_MSCRATCH: mscratch_q <= wval;
        A_MEPC:     mepc_q <= wval & ~XLEN'(3);
        A_MCAUSE:   mcause_q <= wval;
        A_MTVAL:    mtval_q <= wval;
        default: ;
      endcase
    end
  end

  logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;

  assign wr_cyc_lo = wr & (i_addr == A_MCYCLE);
  assign wr_cyc_hi = wr & (i_addr == A_MCYCLEH);
  assign wr_ins_lo = wr & (i_addr == A_MINSTRET);
  assign wr_ins_hi = wr & (i_addr == A_MINSTRETH);

  // writing either half replaces it and skips that counter's increment
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_cyc_lo)
        mcycle_q[XLEN-1:0] <= wval;
      else if (wr_cyc_hi)
        mcycle_q[2*XLEN-1:XLEN] <= wval;
      else
        mcycle_q <= mcycle_q + 1'b1;

      if (wr_ins_lo)
        minstret_q[XLEN-1:0] <= wval;
      else if (wr_ins_hi)
        minstret_q[2*XLEN-1:XLEN] <= wval;
      else if (i_instret)
        minstret_q <= minstret_q + 1'b1;
    end
  end

  assign o_mtvec = mtvec_q;
  assign o_mepc = mepc_q;
  assign o_irq_pending = st_mie & |(mie_q & mip_v);

endmodule
